// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO pair.
// A result is computed at launch, held while busy, and committed when the countdown expires.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic        updatemd,
   input  logic [2:0]  md_control,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_out
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES) + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] count_reg, count_next;
   logic [63:0]   pending_reg, pending_next;
   logic          div_zero_reg, div_zero_next;
   logic [31:0]   hi_reg, hi_next, lo_reg, lo_next;

   logic        start;
   logic        signed_op;
   logic [63:0] a_ext, b_ext, mul_result, div_result;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

   assign start     = start_mult | start_div;
   assign signed_op = ~md_control[0];

   assign a_ext      = {{32{signed_op & A[31]}}, A};
   assign b_ext      = {{32{signed_op & B[31]}}, B};
   assign mul_result = a_ext * b_ext;

   // Divide on magnitudes, then restore signs: quotient truncates toward zero and the
   // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
   assign a_neg      = signed_op & A[31];
   assign b_neg      = signed_op & B[31];
   assign a_mag      = a_neg ? (~A + 32'd1) : A;
   assign b_mag      = b_neg ? (~B + 32'd1) : B;
   assign b_safe     = (B == 32'd0) ? 32'd1 : b_mag;
   assign q_mag      = a_mag / b_safe;
   assign r_mag      = a_mag % b_safe;
   assign quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
   assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
   assign div_result = {rem, quot};

   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      pending_next  = pending_reg;
      div_zero_next = div_zero_reg;
      hi_next       = hi_reg;
      lo_next       = lo_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next    = RUN;
               count_next    = start_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
               pending_next  = md_control[1] ? div_result : mul_result;
               div_zero_next = md_control[1] & (B == 32'd0);
            end else if (updatemd && md_control == 3'b100) begin
               hi_next = A;
            end else if (updatemd && md_control == 3'b101) begin
               lo_next = A;
            end
         end
         RUN: begin
            count_next = count_reg - CW'(1);
            if (count_reg == CW'(1)) begin
               state_next = IDLE;
               if (!div_zero_reg) begin
                  hi_next = pending_reg[63:32];
                  lo_next = pending_reg[31:0];
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         pending_reg  <= '0;
         div_zero_reg <= 1'b0;
         hi_reg       <= '0;
         lo_reg       <= '0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         pending_reg  <= pending_next;
         div_zero_reg <= div_zero_next;
         hi_reg       <= hi_next;
         lo_reg       <= lo_next;
      end
   end

   assign busy     = (state_reg == RUN);
   assign md_stall = busy | start;
   assign hi       = hi_reg;
   assign lo       = lo_reg;
   assign md_out   = md_control[0] ? lo_reg : hi_reg;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers, executed in the EX stage.
- Executes the operations the control unit issues: mult, multu, div, divu, mthi, mtlo, mfhi, mflo.
- Reads operands as they arrive from the forwarding muxes.
- Drives a stall condition back to the hazard logic and a read value for mfhi/mflo writeback.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start_mult  in  1  pulse: launch mult/multu this cycle.
- start_div  in  1  pulse: launch div/divu this cycle.
- updatemd  in  1  instruction in EX targets HI/LO (mult/div/mthi/mtlo).
- md_control  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo.
- A  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- B  in  32  rt operand (divisor / multiplier).
- busy  out  1  operation in flight.
- md_stall  out  1  busy | start_mult | start_div (combinational).
- hi  out  32  HI register.
- lo  out  32  LO register.
- md_out  out  32  md_control[0] ? lo : hi (combinational).

Behaviour:
- Reset values: busy=0, hi=0, lo=0, counter=0, pending result=0.
- Reset overrides everything, including an operation in flight; its result is discarded.
- States: IDLE, RUN.
- IDLE -> RUN on a clock edge with start_mult|start_div while idle.
  - Latch: the 64-bit result computed from A/B/md_control[1:0] that cycle, a div-by-zero flag, and counter = MULT_CYCLES or DIV_CYCLES.
  - busy rises the next cycle.
- RUN: counter decrements each edge.
  - On the edge where counter==1: commit {hi,lo} from the pending result, busy=0, return to IDLE.
  - busy is therefore high for exactly N cycles; new hi/lo are visible the cycle busy falls.
- mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
- multu: same as mult, unsigned.
- div: signed truncating division; lo=quotient, hi=remainder; remainder sign follows dividend.
- divu: same as div, unsigned.
- Division overflow, 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
- Divide by zero (B==0, div or divu):
  - still busy for DIV_CYCLES;
  - hi/lo unchanged at commit.
- mthi/mtlo: when idle and updatemd=1 with md_control=100/101, hi or lo <= A at that edge; the other register is untouched.
- Ignored while busy (hazard logic guarantees stall; unit must still not corrupt state):
  - start_mult, start_div;
  - mthi, mtlo.
- start_mult and start_div both high: start_mult wins; md_control[1:0] still selects the op.
- start_* with updatemd=0: still launches (start is authoritative).
- mfhi/mflo: md_out is combinational from the current hi/lo; no state change.
  - Reading during busy returns the old value (caller stalls on md_stall).
- Back-to-back: start accepted in the cycle busy falls? No. busy falls in the cycle after the commit edge; the unit is idle in that cycle, so a start in that cycle is accepted.
- Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES))+1.

Test Plan:
- mult A=0xFFFFFFFD(-3), B=5, start_mult one cycle:
  - busy high exactly 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFF1;
  - md_stall high during the start cycle.
- multu A=0xFFFFFFFF, B=2:
  - after 5 cycles hi=0x00000001, lo=0xFFFFFFFE;
  - md_control=110 gives md_out=1; 111 gives md_out=0xFFFFFFFE.
- div A=0xFFFFFFF9(-7), B=2:
  - busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- divu A=7, B=0 with prior hi=0x11, lo=0x22:
  - busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
- During a mult in RUN:
  - mthi A=0xDEAD ignored;
  - second start_div ignored;
  - after completion, mtlo A=0xBEEF with updatemd=1 gives lo=0xBEEF next cycle and hi unchanged.
- reset asserted at cycle 4 of a div:
  - next cycle busy=0, hi=lo=0;
  - no later commit;
  - a new mult started afterwards completes normally.
